// File: rtl/simon_job_scheduler.sv
// simon_job_scheduler: round-robin front end that feeds two requesters
// into one shared iterative SIMON datapath and hands back the result.
module simon_job_scheduler #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter int C = 5
) (
    input  logic             clk,
    input  logic             R,
    input  logic             req0_valid,
    input  logic [2*N-1:0]   req0_plain,
    input  logic [M*N-1:0]   req0_key,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2*N-1:0]   req1_plain,
    input  logic [M*N-1:0]   req1_key,
    output logic             req1_ready,
    output logic [2*N-1:0]   core_blk,
    output logic [M*N-1:0]   core_key,
    output logic             core_ld,
    output logic             core_en,
    output logic [C-1:0]     core_count,
    input  logic [2*N-1:0]   core_cipher,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*N-1:0]   res_cipher,
    output logic             res_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [C-1:0] LAST = C'(T - 1);

    state_t         state;
    state_t         nxt;
    logic [2*N-1:0] blk_q;
    logic [M*N-1:0] key_q;
    logic [C-1:0]   cnt;
    logic           owner;
    logic           last;
    logic           gnt0;
    logic           gnt1;
    logic           idle;

    assign idle       = (state == IDLE);
    assign req0_ready = idle && gnt0;
    assign req1_ready = idle && gnt1;
    assign core_blk   = blk_q;
    assign core_key   = key_q;
    assign core_count = cnt;

    // last == 1 means requester 1 was served most recently, so 0 wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (1'b1)
            (req0_valid && req1_valid): begin
                gnt0 = last;
                gnt1 = !last;
            end
            (req0_valid && !req1_valid): gnt0 = 1'b1;
            (!req0_valid && req1_valid): gnt1 = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt     = state;
        core_ld = 1'b0;
        core_en = 1'b0;
        busy    = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (req0_valid || req1_valid) begin
                    nxt = LOAD;
                end
            end
            LOAD: begin
                core_ld = 1'b1;
                nxt     = RUN;
            end
            RUN: begin
                core_en = 1'b1;
                if (cnt == LAST) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            blk_q      <= '0;
            key_q      <= '0;
            cnt        <= '0;
            owner      <= 1'b0;
            last       <= 1'b1;
            res_valid  <= 1'b0;
            res_cipher <= '0;
            res_id     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (gnt1) begin
                        blk_q <= req1_plain;
                        key_q <= req1_key;
                        owner <= 1'b1;
                    end else if (gnt0) begin
                        blk_q <= req0_plain;
                        key_q <= req0_key;
                        owner <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                RUN: begin
                    // the datapath presents the final-round state on this cycle
                    if (cnt == LAST) begin
                        res_cipher <= core_cipher;
                        res_id     <= owner;
                        res_valid  <= 1'b1;
                    end else begin
                        cnt <= cnt + C'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        last      <= owner;
                        cnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_job_scheduler.sv
// tb_simon_job_scheduler: random and directed stimulus against a
// job-level model of the scheduler plus a behavioural SIMON32/64 datapath.
module tb_simon_job_scheduler;

    localparam int N = 16;
    localparam int M = 4;
    localparam int T = 32;
    localparam int C = 5;
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    logic           clk = 1'b0;
    logic           R = 1'b1;
    logic           req0_valid = 1'b0;
    logic           req1_valid = 1'b0;
    logic [2*N-1:0] req0_plain = '0;
    logic [2*N-1:0] req1_plain = '0;
    logic [M*N-1:0] req0_key = '0;
    logic [M*N-1:0] req1_key = '0;
    logic           req0_ready;
    logic           req1_ready;
    logic [2*N-1:0] core_blk;
    logic [M*N-1:0] core_key;
    logic           core_ld;
    logic           core_en;
    logic [C-1:0]   core_count;
    logic [2*N-1:0] core_cipher;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2*N-1:0] res_cipher;
    logic           res_id;
    logic           busy;

    int n_chk = 0;
    int n_fail = 0;

    simon_job_scheduler #(.N(N), .M(M), .T(T), .C(C)) dut (
        .clk(clk), .R(R),
        .req0_valid(req0_valid), .req0_plain(req0_plain),
        .req0_key(req0_key), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_plain(req1_plain),
        .req1_key(req1_key), .req1_ready(req1_ready),
        .core_blk(core_blk), .core_key(core_key),
        .core_ld(core_ld), .core_en(core_en),
        .core_count(core_count), .core_cipher(core_cipher),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_cipher(res_cipher), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rol(input logic [15:0] x, input int s);
        return (x << s) | (x >> (16 - s));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] x, input int s);
        return (x >> s) | (x << (16 - s));
    endfunction

    function automatic logic [15:0] rkey(input logic [63:0] key, input int idx);
        logic [15:0] k [0:31];
        logic [15:0] t;
        logic [61:0] z;
        z = Z0;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i <= idx; i++) begin
            t = ror(k[i-1], 3) ^ k[i-3];
            t = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        return k[idx];
    endfunction

    function automatic logic [31:0] rnd(input logic [31:0] s, input logic [15:0] k);
        logic [15:0] x;
        logic [15:0] y;
        x = s[31:16];
        y = s[15:0];
        return {y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k, x};
    endfunction

    function automatic logic [31:0] simon(input logic [31:0] pt, input logic [63:0] key);
        logic [31:0] s;
        s = pt;
        for (int i = 0; i < 32; i++) s = rnd(s, rkey(key, i));
        return s;
    endfunction

    // shared datapath stand-in: output is the state after the current round
    logic [31:0] dp_st = '0;
    logic [63:0] dp_key = '0;
    int          dp_r = 0;
    always @(posedge clk) begin
        if (core_ld) begin
            dp_st  <= core_blk;
            dp_key <= core_key;
            dp_r   <= 0;
        end else if (core_en) begin
            dp_st <= rnd(dp_st, rkey(dp_key, dp_r));
            if (dp_r < 31) dp_r <= dp_r + 1;
        end
    end
    always_comb core_cipher = rnd(dp_st, rkey(dp_key, dp_r));

    function automatic bit pick(input bit v0, input bit v1, input bit lst);
        return (v0 && v1) ? !lst : v1;
    endfunction

    // job-level model: m_a counts edges since acceptance (1 = just accepted)
    bit          m_busy = 0;
    bit          m_last = 1;
    bit          m_owner = 0;
    int          m_a = 0;
    int          m_jobs = 0;
    logic [31:0] m_blk = '0;
    logic [63:0] m_key = '0;
    logic [31:0] m_cipher = '0;
    always @(posedge clk or posedge R) begin
        bit g;
        if (R) begin
            m_busy <= 0;
            m_a    <= 0;
            m_last <= 1;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                g = pick(req0_valid, req1_valid, m_last);
                m_busy   <= 1;
                m_a      <= 1;
                m_owner  <= g;
                m_blk    <= g ? req1_plain : req0_plain;
                m_key    <= g ? req1_key : req0_key;
                m_cipher <= g ? simon(req1_plain, req1_key)
                              : simon(req0_plain, req0_key);
            end
        end else if (m_a >= T + 2) begin
            if (res_ready) begin
                m_busy <= 0;
                m_last <= m_owner;
                m_jobs <= m_jobs + 1;
            end
        end else begin
            m_a <= m_a + 1;
        end
    end

    int en_cnt = 0;
    int dut_jobs = 0;
    always @(posedge clk or posedge R) begin
        if (R) begin
            en_cnt <= 0;
        end else begin
            if (core_ld) en_cnt <= 0;
            else if (core_en) en_cnt <= en_cnt + 1;
            if (res_valid && res_ready) dut_jobs <= dut_jobs + 1;
        end
    end

    always @(negedge clk) begin
        bit e_r0, e_r1, e_ld, e_en, e_rv, e_busy, g2;
        int e_cnt;
        if (!R) begin
            e_r0 = 0; e_r1 = 0; e_ld = 0; e_en = 0;
            e_rv = 0; e_busy = 1; e_cnt = 0;
            if (!m_busy) begin
                e_busy = 0;
                if (req0_valid || req1_valid) begin
                    g2 = pick(req0_valid, req1_valid, m_last);
                    e_r0 = !g2;
                    e_r1 = g2;
                end
            end else if (m_a == 1) begin
                e_ld = 1;
            end else if (m_a <= T + 1) begin
                e_en = 1;
                e_cnt = m_a - 2;
            end else begin
                e_rv = 1;
                e_cnt = T - 1;
            end
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("one_ready", req0_ready & req1_ready, 0);
            chk("core_ld", core_ld, e_ld);
            chk("core_en", core_en, e_en);
            chk("core_count", core_count, e_cnt);
            chk("busy", busy, e_busy);
            chk("res_valid", res_valid, e_rv);
            if (m_busy && m_a <= T + 1) begin
                chk("core_blk", core_blk, m_blk);
                chk("core_key", core_key, m_key);
            end
            if (e_rv) begin
                chk("res_cipher", res_cipher, m_cipher);
                chk("res_id", res_id, m_owner);
                chk("en_pulses", en_cnt, T);
            end
        end
    end

    task automatic wait_result(input string nm, output int n);
        bit ok;
        n = 0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            n++;
            #1;
            ok = res_valid;
        end
        chk(nm, ok, 1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_count"}, core_count, 0);
        chk({nm, "_ld"}, core_ld, 0);
        chk({nm, "_en"}, core_en, 0);
        chk({nm, "_rv"}, res_valid, 0);
        chk({nm, "_rc"}, res_cipher, 0);
        chk({nm, "_rid"}, res_id, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_blk"}, core_blk, 0);
        chk({nm, "_key"}, core_key, 0);
    endtask

    initial begin
        int n;
        bit found;
        logic [31:0] p;
        logic [63:0] k;
        logic ids [$];

        chk("simon_vector", simon(32'h65656877, 64'h1918111009080100), 32'hc69be9bb);
        #3;
        chk_reset_vals("rst0");
        repeat (2) @(posedge clk);
        #2 R = 0;

        // single job with the published vector, then backpressure
        @(posedge clk);
        #2;
        req0_valid = 1;
        req0_plain = 32'h65656877;
        req0_key = 64'h1918111009080100;
        @(posedge clk);
        #2;
        req0_valid = 0;
        req0_plain = $urandom;
        req0_key = {$urandom, $urandom};
        wait_result("job0_done", n);
        chk("latency", n, T + 1);
        chk("vec_cipher", res_cipher, 32'hc69be9bb);
        chk("vec_id", res_id, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_valid", res_valid, 1);
        chk("bp_cipher", res_cipher, 32'hc69be9bb);
        chk("bp_en", core_en, 0);
        #1 res_ready = 1;
        @(posedge clk);
        #2 res_ready = 0;
        chk("hs_valid", res_valid, 0);
        chk("hs_busy", busy, 0);

        // contention from reset: expect owners 0, 1, 0
        R = 1;
        req0_valid = 1; req0_plain = 32'h01234567; req0_key = {$urandom, $urandom};
        req1_valid = 1; req1_plain = 32'h89abcdef; req1_key = {$urandom, $urandom};
        res_ready = 1;
        @(posedge clk);
        #2 R = 0;
        for (int i = 0; i < 300 && ids.size() < 3; i++) begin
            @(negedge clk);
            if (res_valid) ids.push_back(res_id);
        end
        chk("tie_jobs", ids.size(), 3);
        if (ids.size() == 3) begin
            chk("tie_first", ids[0], 0);
            chk("tie_second", ids[1], 1);
            chk("tie_third", ids[2], 0);
        end
        @(posedge clk);
        #2;
        req0_valid = 0;
        req1_valid = 0;
        res_ready = 0;

        // reset in the middle of a run
        @(posedge clk);
        #2;
        req1_valid = 1; req1_plain = $urandom; req1_key = {$urandom, $urandom};
        @(posedge clk);
        #2 req1_valid = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (core_count == 15) && core_en;
        end
        chk("reach_cnt15", found, 1);
        #1 R = 1;
        #1 chk_reset_vals("rst_run");
        @(posedge clk);
        #2 R = 0;
        p = $urandom;
        k = {$urandom, $urandom};
        @(posedge clk);
        #2;
        req1_valid = 1; req1_plain = p; req1_key = k;
        @(posedge clk);
        #2 req1_valid = 0;
        wait_result("post_rst_done", n);
        chk("post_rst_lat", n, T + 1);
        chk("post_rst_cipher", res_cipher, simon(p, k));
        chk("post_rst_id", res_id, 1);
        #1 res_ready = 1;

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #2;
            req0_valid = ($urandom % 3) == 0;
            req1_valid = ($urandom % 3) == 0;
            req0_plain = $urandom;
            req1_plain = $urandom;
            req0_key = {$urandom, $urandom};
            req1_key = {$urandom, $urandom};
            res_ready = ($urandom % 4) != 0;
        end
        req0_valid = 0;
        req1_valid = 0;
        res_ready = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("job_count", dut_jobs, m_jobs);
        chk("rand_progress", m_jobs >= 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_job_scheduler.md
SIMON_JOB_SCHEDULER -- requirements
Module: simon_job_scheduler

Interface
REQ-001 Parameters SHALL be: N, default 16, word width; M, default 4, key words; T, default 32, rounds; C, default 5, round-counter width.
REQ-002 Ports SHALL be exactly as listed below; clock is clk, reset is R, one clock, reset asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 R  in  1  asynchronous active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 has a job.
REQ-006 req0_plain / req1_plain  in  2N  plaintext block of requester 0/1.
REQ-007 req0_key / req1_key  in  M*N  key of requester 0/1.
REQ-008 req0_ready / req1_ready  out  1  job accepted this cycle.
REQ-009 core_blk  out  2N  block driven to shared SIMON datapath.
REQ-010 core_key  out  M*N  key driven to shared datapath.
REQ-011 core_ld  out  1  datapath load strobe.
REQ-012 core_en  out  1  datapath advance-one-round strobe.
REQ-013 core_count  out  C  current round index.
REQ-014 core_cipher  in  2N  datapath state after last round.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer takes result.
REQ-017 res_cipher  out  2N  ciphertext.
REQ-018 res_id  out  1  requester owning res_cipher.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-021 IDLE: no valid -> stay; any valid -> grant one, capture its plain/key into internal registers, record owner, go LOAD.
REQ-022 Grant: single valid wins; both valid -> requester not served last wins (round-robin).
REQ-023 reqX_ready SHALL be combinational: high only in IDLE, when reqX_valid is high and X is granted; at most one ready high per cycle.
REQ-024 A job is accepted on the rising edge where reqX_valid and reqX_ready are both high; operands SHALL be ignored thereafter.
REQ-025 LOAD: core_ld=1 for exactly one cycle; core_count=0; next state RUN.
REQ-026 RUN: core_en=1 every cycle; core_count increments by 1 per cycle from 0; count==T-1 -> go DONE, else stay.
REQ-027 core_en SHALL pulse exactly T times per job; core_ld and core_en never high together.
REQ-028 core_blk/core_key SHALL show the captured operands from LOAD through end of RUN.
REQ-029 Entering DONE: res_cipher <= core_cipher, res_id <= owner, res_valid <= 1.
REQ-030 DONE: res_valid, res_cipher, res_id held stable until res_ready high at an edge; on that edge res_valid <= 0, last-served <= owner, go IDLE.
REQ-031 Latency: res_valid SHALL rise T+1 edges after the acceptance edge (33 for T=32).
REQ-032 Throughput: a new acceptance is possible no earlier than the cycle after the result handshake; no request accepted while busy.
REQ-033 core_count SHALL not wrap; it holds at T-1 in DONE and returns to 0 in IDLE.
REQ-034 Requester valid dropped before acceptance SHALL produce no job and no state change.

Reset
REQ-035 R high SHALL immediately, independent of clk, force: state IDLE, core_count 0, core_ld 0, core_en 0, res_valid 0, res_cipher 0, res_id 0, busy 0, captured operands 0, last-served = 1 (requester 0 wins first tie).
REQ-036 R asserted mid-RUN or in DONE SHALL abort the job with no result output; operation resumes from IDLE on first edge after R falls.

Verification
REQ-037 Single job: req0_valid=1, plain=0x65656877, key=0x1918_1110_0908_0100 -> req0_ready one cycle, core_ld one pulse, 32 core_en pulses, res_valid after 33 edges, res_cipher=0xc69be9bb, res_id=0.
REQ-038 Contention: both valid from reset -> requester 0 served first, requester 1 accepted the cycle after result handshake; repeat tie -> 0 again (alternation).
REQ-039 Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid, res_cipher, res_id stable, no ready asserted, core_en 0.
REQ-040 Reset mid-RUN at core_count=15 -> all outputs to reset values asynchronously; no res_valid; next request completes normally.
REQ-041 Protocol checks: never both readies high, core_en count per job = 32, core_ld before first core_en, core_count sequence 0..31 without gaps.
